seq_radix_multiplier: RTL and testbench

Parametrised iterative multiplier, successor to two_bit_multiplier2. It retires K multiplier bits per cycle, with configurable operand widths and a per-transaction signed/unsigned mode. It uses a valid/ready handshake on both input and output, and terminates early once the remaining multiplier digits are zero. It is a drop-in arithmetic unit for datapaths that tolerate variable latency.

---
 rtl/seq_mult_pkg.sv | 27 ++
 rtl/mult_digit_pp.sv | 31 +++
 rtl/seq_radix_multiplier.sv | 140 ++++++++++++++
 tb/tb_seq_radix_multiplier.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_mult_pkg : shared types, defaults and helpers for seq_radix_multiplier |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEF_A_W = 16;
   localparam int DEF_B_W = 16;
   localparam int DEF_K   = 2;

   // Bits needed to count up to n-1; never less than one.
   function automatic int clog2ceil(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r = r + 1;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mult_digit_pp.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mult_digit_pp : combinational P x K partial product (operand times digit)  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module mult_digit_pp
   import seq_mult_pkg::*;
#(
   parameter int P = DEF_A_W + DEF_B_W,
   parameter int K = DEF_K
) (
   input  logic [P-1:0] i_a,
   input  logic [K-1:0] i_digit,
   output logic [P-1:0] o_pp
);

   logic [P-1:0] w_row [K];

   for (genvar j = 0; j < K; j++) begin : g_row
      assign w_row[j] = i_digit[j] ? (i_a << j) : '0;
   end

   always_comb begin
      o_pp = '0;
      for (int j = 0; j < K; j++) begin
         o_pp = o_pp + w_row[j];
      end
   end

endmodule
`default_nettype wire

// File: rtl/seq_radix_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | seq_radix_multiplier : radix-2^K iterative multiplier, early termination   |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module seq_radix_multiplier
   import seq_mult_pkg::*;
#(
   parameter int A_W = DEF_A_W,
   parameter int B_W = DEF_B_W,
   parameter int K   = DEF_K
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_vld,
   output logic               in_rdy,
   input  logic [A_W-1:0]     a,
   input  logic [B_W-1:0]     b,
   input  logic               is_signed,
   output logic               out_vld,
   input  logic               out_rdy,
   output logic [A_W+B_W-1:0] c,
   output logic               busy
);

   localparam int P     = A_W + B_W;
   localparam int ND    = (P + K - 1) / K;
   localparam int NDK   = ND * K;
   localparam int CNT_W = clog2ceil(ND);

   state_e             r_state;
   state_e             w_state_nxt;
   logic [P-1:0]       r_a;
   logic [NDK-1:0]     r_b;
   logic [P-1:0]       r_acc;
   logic [P-1:0]       r_c;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_out_vld;

   logic [P-1:0]       w_a_ext;
   logic [P-1:0]       w_b_p;
   logic [NDK-1:0]     w_b_ext;
   logic [NDK-1:0]     w_b_shift;
   logic [P-1:0]       w_pp;
   logic [P-1:0]       w_acc_nxt;
   logic               w_last;

   always_comb begin
      w_a_ext = {{B_W{is_signed & a[A_W-1]}}, a};
      w_b_p   = {{A_W{is_signed & b[B_W-1]}}, b};
      // Pad so the top digit is whole when K does not divide P.
      w_b_ext          = '0;
      w_b_ext[P-1:0]   = w_b_p;
   end

   mult_digit_pp #(
      .P (P),
      .K (K)
   ) u_pp (
      .i_a     (r_a),
      .i_digit (r_b[K-1:0]),
      .o_pp    (w_pp)
   );

   assign w_acc_nxt = r_acc + w_pp;
   assign w_b_shift = r_b >> K;
   assign w_last    = (w_b_shift == '0) || (r_cnt == CNT_W'(ND - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      in_rdy      = 1'b0;
      busy        = 1'b1;
      case (r_state)
         IDLE: begin
            in_rdy = 1'b1;
            busy   = 1'b0;
            if (in_vld) w_state_nxt = CALC;
         end
         CALC: begin
            if (w_last) w_state_nxt = DONE;
         end
         DONE: begin
            if (out_rdy) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_c       <= '0;
         r_cnt     <= '0;
         r_out_vld <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_vld) begin
                  r_a   <= w_a_ext;
                  r_b   <= w_b_ext;
                  r_acc <= '0;
                  r_cnt <= '0;
               end
            end
            CALC: begin
               r_acc <= w_acc_nxt;
               r_a   <= r_a << K;
               r_b   <= w_b_shift;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  r_c       <= w_acc_nxt;
                  r_out_vld <= 1'b1;
               end
            end
            DONE: begin
               if (out_rdy) r_out_vld <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign out_vld = r_out_vld;
   assign c       = r_c;

endmodule
`default_nettype wire

// File: tb/tb_seq_radix_multiplier.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_seq_radix_multiplier : directed and randomized bench, three param sets  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_seq_radix_multiplier;

   localparam int AWS [3] = '{16, 16, 8};
   localparam int BWS [3] = '{16, 16, 12};
   localparam int KS  [3] = '{2, 1, 3};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [2:0]  in_vld, out_rdy, sg;
   logic [15:0] a0, b0, a1, b1;
   logic [7:0]  a2;
   logic [11:0] b2;
   logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, bsy0, bsy1, bsy2;
   logic [31:0] c0, c1;
   logic [19:0] c2;

   int vectors = 0;
   int errors  = 0;

   seq_radix_multiplier #(.A_W(16), .B_W(16), .K(2)) u_dut0 (
      .clk(clk), .rst(rst), .in_vld(in_vld[0]), .in_rdy(rdy0), .a(a0), .b(b0),
      .is_signed(sg[0]), .out_vld(vld0), .out_rdy(out_rdy[0]), .c(c0), .busy(bsy0));
   seq_radix_multiplier #(.A_W(16), .B_W(16), .K(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_vld(in_vld[1]), .in_rdy(rdy1), .a(a1), .b(b1),
      .is_signed(sg[1]), .out_vld(vld1), .out_rdy(out_rdy[1]), .c(c1), .busy(bsy1));
   seq_radix_multiplier #(.A_W(8), .B_W(12), .K(3)) u_dut2 (
      .clk(clk), .rst(rst), .in_vld(in_vld[2]), .in_rdy(rdy2), .a(a2), .b(b2),
      .is_signed(sg[2]), .out_vld(vld2), .out_rdy(out_rdy[2]), .c(c2), .busy(bsy2));

   function automatic logic [31:0] c_of(input int u);
      case (u)
         0:       return c0;
         1:       return c1;
         default: return {12'd0, c2};
      endcase
   endfunction
   function automatic logic rdy_of(input int u);
      case (u) 0: return rdy0; 1: return rdy1; default: return rdy2; endcase
   endfunction
   function automatic logic vld_of(input int u);
      case (u) 0: return vld0; 1: return vld1; default: return vld2; endcase
   endfunction
   function automatic logic bsy_of(input int u);
      case (u) 0: return bsy0; 1: return bsy1; default: return bsy2; endcase
   endfunction

   task automatic set_ops(input int u, input logic [31:0] av, input logic [31:0] bv);
      case (u)
         0:       begin a0 = av[15:0]; b0 = bv[15:0];  end
         1:       begin a1 = av[15:0]; b1 = bv[15:0];  end
         default: begin a2 = av[7:0];  b2 = bv[11:0];  end
      endcase
   endtask

   // Reference: interpret operands as integers, multiply, reduce mod 2^P.
   function automatic longint ext_val(input logic [31:0] v, input int w, input logic s);
      longint e;
      e = longint'({32'd0, v}) & ((64'sd1 <<< w) - 1);
      if (s && e[w-1]) e = e - (64'sd1 <<< w);
      return e;
   endfunction

   function automatic logic [31:0] ref_prod(input int u, input logic [31:0] av,
                                            input logic [31:0] bv, input logic s);
      longint pr;
      int     p;
      p  = AWS[u] + BWS[u];
      pr = ext_val(av, AWS[u], s) * ext_val(bv, BWS[u], s);
      return 32'(pr & ((64'sd1 <<< p) - 1));
   endfunction

   // Latency = 1 + index of the most significant nonzero radix-2^K digit.
   function automatic int ref_lat(input int u, input logic [31:0] bv, input logic s);
      longint bx;
      int     p, k, nd, l;
      p  = AWS[u] + BWS[u];
      k  = KS[u];
      nd = (p + k - 1) / k;
      bx = ext_val(bv, BWS[u], s) & ((64'sd1 <<< p) - 1);
      l  = 1;
      for (int i = 0; i < nd; i++) begin
         if (((bx >> (i * k)) & ((64'sd1 <<< k) - 1)) != 0) l = i + 1;
      end
      return l;
   endfunction

   // Issue one transaction from a negedge; returns result and cycles from accept.
   task automatic do_txn(input int u, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, output logic [31:0] cg, output int lat);
      vectors++;
      if (rdy_of(u) !== 1'b1) begin
         errors++;
         $display("FAIL in_rdy_at_issue u%0d got %b want 1", u, rdy_of(u));
      end
      set_ops(u, av, bv);
      sg[u]     = s;
      in_vld[u] = 1'b1;
      @(negedge clk);
      in_vld[u] = 1'b0;
      set_ops(u, $urandom, $urandom);
      sg[u] = 1'($urandom_range(0, 1));
      lat = 0;
      while (vld_of(u) !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      cg = c_of(u);
      out_rdy[u] = 1'b1;
      @(negedge clk);
      out_rdy[u] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int u = 0; u < 3; u++) begin
         vectors++; if (vld_of(u) !== 1'b0) begin errors++; $display("FAIL rst_out_vld u%0d got %b want 0", u, vld_of(u)); end
         vectors++; if (c_of(u) !== 32'd0) begin errors++; $display("FAIL rst_c u%0d got %h want 0", u, c_of(u)); end
         vectors++; if (rdy_of(u) !== 1'b1) begin errors++; $display("FAIL rst_in_rdy u%0d got %b want 1", u, rdy_of(u)); end
         vectors++; if (bsy_of(u) !== 1'b0) begin errors++; $display("FAIL rst_busy u%0d got %b want 0", u, bsy_of(u)); end
      end
   endtask

   task automatic test_directed();
      logic [31:0] ta [7] = '{32'h4, 32'hFFFF, 32'h1234, 32'h0, 32'hFFFD, 32'h5, 32'h8000};
      logic [31:0] tb [7] = '{32'h5, 32'hFFFF, 32'h0, 32'h8000, 32'h7, 32'hFFFE, 32'h8000};
      logic        ts [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] ec [7] = '{32'd20, 32'hFFFE0001, 32'h0, 32'h0, 32'hFFFFFFEB, 32'hFFFFFFF6, 32'h40000000};
      int          el [7] = '{2, 8, 1, 8, 2, 16, 16};
      logic [31:0] cg;
      int          lat;
      for (int i = 0; i < 7; i++) begin
         do_txn(0, ta[i], tb[i], ts[i], cg, lat);
         vectors++; if (cg !== ec[i]) begin errors++; $display("FAIL dir_c #%0d got %h want %h", i, cg, ec[i]); end
         vectors++; if (lat != el[i]) begin errors++; $display("FAIL dir_lat #%0d got %0d want %0d", i, lat, el[i]); end
      end
   endtask

   task automatic test_backpressure();
      int wt;
      set_ops(0, 9, 3);
      sg[0]     = 1'b0;
      in_vld[0] = 1'b1;
      @(negedge clk);
      set_ops(0, 5, 5);
      wt = 0;
      while (vld0 !== 1'b1 && wt < 100) begin @(negedge clk); wt++; end
      for (int k = 0; k < 5; k++) begin
         vectors++; if (vld0 !== 1'b1) begin errors++; $display("FAIL bp_out_vld cyc%0d got %b want 1", k, vld0); end
         vectors++; if (c0 !== 32'd27) begin errors++; $display("FAIL bp_c cyc%0d got %0d want 27", k, c0); end
         vectors++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL bp_in_rdy cyc%0d got %b want 0", k, rdy0); end
         @(negedge clk);
      end
      out_rdy[0] = 1'b1;
      set_ops(0, 2, 3);
      @(negedge clk);
      out_rdy[0] = 1'b0;
      vectors++; if (vld0 !== 1'b0) begin errors++; $display("FAIL bp_release_vld got %b want 0", vld0); end
      vectors++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", rdy0); end
      vectors++; if (c0 !== 32'd27) begin errors++; $display("FAIL bp_c_hold got %0d want 27", c0); end
      @(negedge clk);
      in_vld[0] = 1'b0;
      vectors++; if (bsy0 !== 1'b1) begin errors++; $display("FAIL bp_next_accept busy got %b want 1", bsy0); end
      wt = 0;
      while (vld0 !== 1'b1 && wt < 100) begin @(negedge clk); wt++; end
      vectors++; if (c0 !== 32'd6) begin errors++; $display("FAIL bp_next_c got %0d want 6", c0); end
      out_rdy[0] = 1'b1;
      @(negedge clk);
      out_rdy[0] = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] cg;
      int          lat;
      set_ops(0, 32'hFFFF, 32'hFFFF);
      sg[0]     = 1'b0;
      in_vld[0] = 1'b1;
      @(negedge clk);
      in_vld[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rmid_out_vld got %b want 0", vld0); end
      vectors++; if (c0 !== 32'd0) begin errors++; $display("FAIL rmid_c got %h want 0", c0); end
      vectors++; if (bsy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bsy0); end
      vectors++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rmid_in_rdy got %b want 1", rdy0); end
      do_txn(0, 6, 7, 1'b0, cg, lat);
      vectors++; if (cg !== 32'd42) begin errors++; $display("FAIL rmid_fresh_c got %0d want 42", cg); end
      // Reset while the result waits in DONE.
      set_ops(0, 3, 3);
      in_vld[0] = 1'b1;
      @(negedge clk);
      in_vld[0] = 1'b0;
      lat = 0;
      while (vld0 !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      vectors++; if (vld0 !== 1'b0 || c0 !== 32'd0 || rdy0 !== 1'b1) begin
         errors++; $display("FAIL rdone_state got vld=%b c=%h rdy=%b want vld=0 c=0 rdy=1", vld0, c0, rdy0);
      end
   endtask

   task automatic test_random(input int u, input int n);
      logic [31:0] av, bv, cg, ec;
      logic        s;
      int          lat, el;
      for (int i = 0; i < n; i++) begin
         av = $urandom;
         bv = $urandom >> $urandom_range(0, 31);
         s  = 1'($urandom_range(0, 1));
         ec = ref_prod(u, av, bv, s);
         el = ref_lat(u, bv, s);
         do_txn(u, av, bv, s, cg, lat);
         vectors++; if (cg !== ec) begin errors++; $display("FAIL rnd_c u%0d a=%h b=%h s=%b got %h want %h", u, av, bv, s, cg, ec); end
         vectors++; if (lat != el) begin errors++; $display("FAIL rnd_lat u%0d b=%h s=%b got %0d want %0d", u, bv, s, lat, el); end
      end
   endtask

   initial begin
      rst     = 1'b1;
      in_vld  = '0;
      out_rdy = '0;
      sg      = '0;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0; a2 = '0; b2 = '0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random(0, 1500);
      test_random(1, 600);
      test_random(2, 1200);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
`default_nettype wire
